// File: rtl/cnn_header_reader.sv
// Reads and validates the CNN parameter RAM header, then streams one descriptor per
// conv layer followed by one per dense layer to the layer sequencer.
module cnn_header_reader #(
    parameter int MAX_LAYERS = 10,
    parameter int WORD_BYTES = 1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    output logic [15:0] ramAddress,
    output logic        readSignal,
    input  logic [7:0]  ramDataOut,
    output logic [7:0]  cfg_filter_size,
    output logic [7:0]  cfg_num_layers,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic        desc_is_dense,
    output logic [3:0]  desc_layer,
    output logic [7:0]  desc_count,
    output logic [15:0] desc_base,
    output logic [15:0] desc_bias,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int CNT_DEPTH = 2 * MAX_LAYERS - 1;
    localparam int IDX_W     = (CNT_DEPTH > 1) ? $clog2(CNT_DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, HDR, CNT, EMIT_CONV, EMIT_DENSE, FIN} state_t;
    state_t state, stateNext;

    logic [7:0]       counts [CNT_DEPTH];
    logic [15:0]      filterOffset, denseOffset;
    logic             capValid;
    logic [15:0]      capAddr;
    logic             mismatch;

    logic             hdrBad, handshake, lastConv, lastDense, endMismatch, capInRange;
    logic [IDX_W-1:0] capIdx;
    logic [15:0]      lastAddr, fsSq, nextConvBase, nextConvBias, firstBias;
    logic [7:0]       firstCount, nextConvCount, nextDenseCount, denseFirstCount;

    // WORD_BYTES * nf * mult, reduced mod 2^16
    function automatic logic [15:0] scaled(input logic [7:0] nf, input logic [15:0] mult);
        int p;
        p = WORD_BYTES * int'(nf) * int'(mult);
        return p[15:0];
    endfunction

    function automatic logic [7:0] countAt(input int idx);
        if (idx >= 0 && idx < CNT_DEPTH)
            return counts[idx[IDX_W-1:0]];
        return 8'd0;
    endfunction

    always_comb begin
        hdrBad          = (cfg_num_layers == 8'd0) || (int'(cfg_num_layers) > MAX_LAYERS);
        lastAddr        = {7'd0, cfg_num_layers, 1'b0} + 16'd4;
        handshake       = (state == EMIT_CONV || state == EMIT_DENSE) && desc_ready;
        lastConv        = ({4'd0, desc_layer} == cfg_num_layers - 8'd1);
        lastDense       = ({4'd0, desc_layer} == cfg_num_layers - 8'd2);
        fsSq            = {8'd0, cfg_filter_size} * {8'd0, cfg_filter_size};
        nextConvBase    = desc_bias + scaled(desc_count, 16'd1);
        nextConvCount   = countAt(int'(desc_layer) + 1);
        nextConvBias    = nextConvBase + scaled(nextConvCount, fsSq);
        nextDenseCount  = countAt(int'(cfg_num_layers) + int'(desc_layer) + 1);
        denseFirstCount = countAt(int'(cfg_num_layers));
        // With a single layer the only count is still on the read bus when descriptor 0 loads
        firstCount      = (cfg_num_layers == 8'd1) ? ramDataOut : countAt(0);
        firstBias       = filterOffset + scaled(firstCount, fsSq);
        endMismatch     = (state == EMIT_CONV) && handshake && lastConv && (nextConvBase != denseOffset);
        capInRange      = (capAddr >= 16'd6) && (int'(capAddr) < 6 + CNT_DEPTH);
        capIdx          = IDX_W'(capAddr - 16'd6);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        desc_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: if (start) stateNext = HDR;
            HDR: begin
                busy = 1'b1;
                if (ramAddress == 16'd5) stateNext = hdrBad ? FIN : CNT;
            end
            CNT: begin
                busy = 1'b1;
                // readSignal low here means the last count is arriving this cycle
                if (!readSignal) stateNext = EMIT_CONV;
            end
            EMIT_CONV: begin
                busy       = 1'b1;
                desc_valid = 1'b1;
                if (handshake && lastConv)
                    stateNext = (cfg_num_layers == 8'd1) ? FIN : EMIT_DENSE;
            end
            EMIT_DENSE: begin
                busy       = 1'b1;
                desc_valid = 1'b1;
                if (handshake && lastDense) stateNext = FIN;
            end
            FIN: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ramAddress      <= '0;
            readSignal      <= 1'b0;
            cfg_filter_size <= '0;
            cfg_num_layers  <= '0;
            filterOffset    <= '0;
            denseOffset     <= '0;
            capValid        <= 1'b0;
            capAddr         <= '0;
            mismatch        <= 1'b0;
            err             <= 1'b0;
            desc_is_dense   <= 1'b0;
            desc_layer      <= '0;
            desc_count      <= '0;
            desc_base       <= '0;
            desc_bias       <= '0;
            for (int i = 0; i < CNT_DEPTH; i++) counts[i] <= '0;
        end else begin
            capValid <= readSignal;
            capAddr  <= ramAddress;
            if (capValid) begin
                case (capAddr)
                    16'd0: cfg_filter_size    <= ramDataOut;
                    16'd1: cfg_num_layers     <= ramDataOut;
                    16'd2: filterOffset[15:8] <= ramDataOut;
                    16'd3: filterOffset[7:0]  <= ramDataOut;
                    16'd4: denseOffset[15:8]  <= ramDataOut;
                    16'd5: denseOffset[7:0]   <= ramDataOut;
                    default: if (capInRange) counts[capIdx] <= ramDataOut;
                endcase
            end

            case (state)
                IDLE: if (start) begin
                    ramAddress <= '0;
                    readSignal <= 1'b1;
                    err        <= 1'b0;
                    mismatch   <= 1'b0;
                end
                HDR: begin
                    if (ramAddress == 16'd5 && hdrBad) readSignal <= 1'b0;
                    else                               ramAddress <= ramAddress + 16'd1;
                end
                CNT: begin
                    if (readSignal) begin
                        if (ramAddress == lastAddr) readSignal <= 1'b0;
                        else                        ramAddress <= ramAddress + 16'd1;
                    end else begin
                        desc_is_dense <= 1'b0;
                        desc_layer    <= '0;
                        desc_count    <= firstCount;
                        desc_base     <= filterOffset;
                        desc_bias     <= firstBias;
                    end
                end
                EMIT_CONV: if (handshake) begin
                    if (endMismatch) mismatch <= 1'b1;
                    if (lastConv) begin
                        desc_is_dense <= 1'b1;
                        desc_layer    <= '0;
                        desc_count    <= denseFirstCount;
                        desc_base     <= denseOffset;
                        desc_bias     <= '0;
                    end else begin
                        desc_layer    <= desc_layer + 4'd1;
                        desc_count    <= nextConvCount;
                        desc_base     <= nextConvBase;
                        desc_bias     <= nextConvBias;
                    end
                end
                EMIT_DENSE: if (handshake && !lastDense) begin
                    desc_layer <= desc_layer + 4'd1;
                    desc_count <= nextDenseCount;
                end
                default: ;
            endcase

            // err appears together with the done pulse
            if (stateNext == FIN && state != FIN)
                err <= hdrBad | mismatch | endMismatch;
        end
    end
endmodule

// File: tb/tb_cnn_header_reader.sv
// Scoreboard bench for cnn_header_reader: stimulus queues expected reads, descriptors
// and done events; a negedge monitor pops and compares as the DUT presents them.
module tb_cnn_header_reader;
    logic        clk = 1'b0, RST = 1'b0, start = 1'b0, desc_ready = 1'b1;
    logic [15:0] ramAddress;
    logic        readSignal;
    logic [7:0]  ramDataOut = 8'd0;
    logic [7:0]  cfg_filter_size, cfg_num_layers;
    logic        desc_valid, desc_is_dense, busy, done, err;
    logic [3:0]  desc_layer;
    logic [7:0]  desc_count;
    logic [15:0] desc_base, desc_bias;

    always #5 clk = ~clk;

    cnn_header_reader #(.MAX_LAYERS(10), .WORD_BYTES(1)) dut (
        .clk(clk), .RST(RST), .start(start), .ramAddress(ramAddress), .readSignal(readSignal),
        .ramDataOut(ramDataOut), .cfg_filter_size(cfg_filter_size), .cfg_num_layers(cfg_num_layers),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_is_dense(desc_is_dense),
        .desc_layer(desc_layer), .desc_count(desc_count), .desc_base(desc_base),
        .desc_bias(desc_bias), .busy(busy), .done(done), .err(err));

    logic [7:0] mem [65536];
    always @(posedge clk) if (readSignal) ramDataOut <= mem[ramAddress];

    typedef struct packed {
        logic        dense;
        logic [3:0]  layer;
        logic [7:0]  count;
        logic [15:0] base;
        logic [15:0] bias;
    } desc_t;

    desc_t expQ[$];
    int    expAddrQ[$];
    logic  expDoneErr[$];
    int    expDoneCyc[$];
    int    checks = 0, errors = 0;
    int    cyc = 0, startCyc = 0, expFirstCyc = 0;
    bit    sawFirst = 0, doneSeen = 0, prevStall = 0, stallEn = 0;
    int    stallCnt = 0;
    desc_t held;
    logic [7:0] cv [20];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=0x%0h required=none", name, act);
    endtask

    // Ready driver: optionally withholds ready for 5 cycles on conv layer 1
    always @(posedge clk) begin
        #1;
        if (stallEn && desc_valid && !desc_is_dense && desc_layer == 4'd1 && stallCnt < 5) begin
            desc_ready = 1'b0;
            stallCnt++;
        end else begin
            desc_ready = 1'b1;
        end
    end

    always @(negedge clk) if (RST) begin
        int    rel;
        desc_t cur;
        rel = cyc - startCyc;
        cur = {desc_is_dense, desc_layer, desc_count, desc_base, desc_bias};
        if (readSignal) begin
            if (expAddrQ.size() == 0) failNow("read_extra", ramAddress);
            else check("read_addr", ramAddress, expAddrQ.pop_front());
        end
        if (desc_valid) begin
            if (!sawFirst) begin
                sawFirst = 1;
                check("first_valid_cycle", rel, expFirstCyc);
            end
            if (prevStall) check("desc_hold", cur, held);
            if (desc_ready) begin
                if (expQ.size() == 0) failNow("desc_extra", cur);
                else check("desc", cur, expQ.pop_front());
            end
            prevStall = !desc_ready;
            held      = cur;
        end else if (prevStall) begin
            failNow("valid_dropped", held);
            prevStall = 0;
        end
        if (done) begin
            doneSeen = 1;
            check("busy_at_done", busy, 1'b0);
            if (expDoneErr.size() == 0) failNow("done_extra", rel);
            else begin
                check("done_err", err, expDoneErr.pop_front());
                check("done_cycle", rel, expDoneCyc.pop_front());
            end
        end
    end

    // Loads RAM and pushes every expected read, descriptor and done event for one run
    task automatic prep(input logic [7:0] fs, input logic [7:0] n, input logic [15:0] fo,
                        input logic [15:0] dof, input bit stall, input logic expErr);
        bit          bad;
        logic [15:0] base, bias;
        int          nl;
        nl  = int'(n);
        bad = (nl == 0) || (nl > 10);
        mem[0] = fs; mem[1] = n;
        mem[2] = fo[15:8]; mem[3] = fo[7:0];
        mem[4] = dof[15:8]; mem[5] = dof[7:0];
        for (int a = 0; a < 6; a++) expAddrQ.push_back(a);
        if (bad) begin
            expDoneErr.push_back(1'b1);
            expDoneCyc.push_back(7);
        end else begin
            for (int i = 0; i < 2 * nl - 1; i++) begin
                mem[6 + i] = cv[i];
                expAddrQ.push_back(6 + i);
            end
            base = fo;
            for (int i = 0; i < nl; i++) begin
                bias = base + fs * fs * cv[i];
                expQ.push_back({1'b0, 4'(i), cv[i], base, bias});
                base = bias + cv[i];
            end
            for (int j = 0; j < nl - 1; j++)
                expQ.push_back({1'b1, 4'(j), cv[nl + j], dof, 16'd0});
            expFirstCyc = 2 * nl + 7;
            expDoneErr.push_back(expErr);
            expDoneCyc.push_back(2 * nl + 7 + (2 * nl - 1) + ((stall && nl > 1) ? 5 : 0));
        end
        stallEn  = stall;
        stallCnt = 0;
        sawFirst = 0;
        doneSeen = 0;
    endtask

    task automatic pulseStart();
        @(posedge clk); #2;
        start    = 1'b1;
        startCyc = cyc;
        @(posedge clk); #2;
        start    = 1'b0;
    endtask

    task automatic runCase(input string tag, input logic [7:0] fs, input logic [7:0] n,
                           input logic [15:0] fo, input logic [15:0] dof, input bit stall,
                           input logic expErr);
        prep(fs, n, fo, dof, stall, expErr);
        pulseStart();
        @(negedge clk);
        check({tag, "_busy_c1"}, busy, 1'b1);
        check({tag, "_err_c1"}, err, 1'b0);
        for (int i = 0; i < 300 && !doneSeen; i++) @(posedge clk);
        if (!doneSeen) failNow({tag, "_done_timeout"}, cyc - startCyc);
        repeat (3) @(negedge clk);
        check({tag, "_desc_left"}, expQ.size(), 0);
        check({tag, "_reads_left"}, expAddrQ.size(), 0);
        check({tag, "_done_left"}, expDoneErr.size(), 0);
        check({tag, "_cfg_fs"}, cfg_filter_size, fs);
        check({tag, "_cfg_n"}, cfg_num_layers, n);
        check({tag, "_err_held"}, err, expErr);
        expQ.delete(); expAddrQ.delete(); expDoneErr.delete(); expDoneCyc.delete();
    endtask

    task automatic loadA();
        cv[0] = 8'd6; cv[1] = 8'd6; cv[2] = 8'd6; cv[3] = 8'd12; cv[4] = 8'd12;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ctl"}, {ramAddress, readSignal, cfg_filter_size, cfg_num_layers,
                              desc_valid, busy, done, err}, 64'd0);
        check({tag, "_desc"}, {desc_is_dense, desc_layer, desc_count, desc_base, desc_bias}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 20; i++) cv[i] = 8'd0;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #2;
        RST = 1'b1;

        // conv (6,11,17) (6,23,29) (6,35,41), dense (12,47,0) x2
        loadA();
        runCase("basic", 8'd1, 8'd3, 16'd11, 16'd47, 1'b0, 1'b0);
        runCase("stall", 8'd1, 8'd3, 16'd11, 16'd47, 1'b1, 1'b0);
        runCase("endmis", 8'd1, 8'd3, 16'd11, 16'd48, 1'b0, 1'b1);
        runCase("errclr", 8'd1, 8'd3, 16'd11, 16'd47, 1'b0, 1'b0);
        runCase("n0", 8'd1, 8'd0, 16'd11, 16'd47, 1'b0, 1'b1);
        runCase("n11", 8'd1, 8'd11, 16'd11, 16'd47, 1'b0, 1'b1);

        // single conv (8,7,79), end 87
        cv[0] = 8'd8;
        runCase("n1", 8'd3, 8'd1, 16'd7, 16'd87, 1'b0, 1'b0);

        // zero count: conv0 (0,100,100), conv1 (5,100,120), end 125
        cv[0] = 8'd0; cv[1] = 8'd5; cv[2] = 8'd9;
        runCase("zero", 8'd2, 8'd2, 16'd100, 16'd125, 1'b0, 1'b0);

        // max layers with address wrap: 0xFFF0 + 2*(1+..+10) = 0x005E mod 2^16
        for (int i = 0; i < 10; i++) cv[i] = 8'(i + 1);
        for (int j = 0; j < 9; j++) cv[10 + j] = 8'(20 + j);
        runCase("n10", 8'd1, 8'd10, 16'hFFF0, 16'h005E, 1'b0, 1'b0);

        // reset in the middle of count reads, then a clean rerun
        loadA();
        prep(8'd1, 8'd3, 16'd11, 16'd47, 1'b0, 1'b0);
        pulseStart();
        repeat (7) @(posedge clk);
        #2;
        RST = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("midrst");
        expQ.delete(); expAddrQ.delete(); expDoneErr.delete(); expDoneCyc.delete();
        prevStall = 0;
        @(posedge clk); #2;
        RST = 1'b1;
        runCase("after_rst", 8'd1, 8'd3, 16'd11, 16'd47, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
